// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and the
// operand latch record used by the EX-stage engine, the controller and ID/EX.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;    // rs: dividend / multiplicand
        logic [31:0] b;    // rt: divisor / multiplier
    } md_req_t;

endpackage

// File: rtl/mult_div_arith.sv
// Combinational result path: latched operands + op -> {HI,LO}, including the
// MIPS-style divide-by-zero and signed-overflow results (no trap).
module mult_div_arith
    import md_pkg::*;
(
    input  md_req_t     i_req,
    output logic [63:0] o_res
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero;
    logic               w_ovf;
    logic        [31:0] w_div_u;
    logic        [31:0] w_div_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{i_req.a[31]}}, i_req.a}) * $signed({{32{i_req.b[31]}}, i_req.b});
    assign w_prod_u = {32'd0, i_req.a} * {32'd0, i_req.b};

    assign w_b_zero = (i_req.b == 32'd0);
    assign w_ovf    = (i_req.a == 32'h8000_0000) && (i_req.b == 32'hFFFF_FFFF);

    // Divisors are steered away from the special cases so the dividers never see them.
    assign w_div_u  = w_b_zero ? 32'd1 : i_req.b;
    assign w_div_s  = (w_b_zero || w_ovf) ? 32'd1 : i_req.b;

    assign w_quo_s  = $signed(i_req.a) / $signed(w_div_s);
    assign w_rem_s  = $signed(i_req.a) % $signed(w_div_s);
    assign w_quo_u  = i_req.a / w_div_u;
    assign w_rem_u  = i_req.a % w_div_u;

    always_comb begin
        o_res = 64'd0;
        case (i_req.op)
            MD_MULT:  o_res = w_prod_s;
            MD_MULTU: o_res = w_prod_u;
            MD_DIV: begin
                if (w_b_zero)   o_res = {i_req.a, 32'hFFFF_FFFF};
                else if (w_ovf) o_res = {32'd0, 32'h8000_0000};
                else            o_res = {w_rem_s, w_quo_s};
            end
            MD_DIVU: begin
                if (w_b_zero)   o_res = {i_req.a, 32'hFFFF_FFFF};
                else            o_res = {w_rem_u, w_quo_u};
            end
            default:  o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide engine: owns HI/LO, models fixed multi-cycle latency
// and exports busy so the hazard unit can hold ID/EX.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic        i_cancel,
    input  logic        i_hilo_we,
    input  logic        i_hilo_sel,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    md_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    md_req_t          r_req;
    logic [31:0]      r_hi, r_lo;
    logic             r_done;
    logic             w_idle, w_accept, w_mt, w_last;
    logic [63:0]      w_res;

    assign w_idle   = (r_state == MD_IDLE);
    assign w_accept = w_idle && i_start && !i_cancel;
    // Start outranks mthi/mtlo in the same cycle.
    assign w_mt     = w_idle && i_hilo_we && !i_start && !i_cancel;
    assign w_last   = (r_state == MD_BUSY) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_accept) w_state_nxt = MD_BUSY;
            MD_BUSY: if (w_last)   w_state_nxt = MD_IDLE;
            default:               w_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MD_BUSY);
        o_done = r_done;
        o_hi   = r_hi;
        o_lo   = r_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_req <= '0;
        end else if (w_accept) begin
            r_cnt <= i_op[1] ? DIV_CNT : MULT_CNT;
            r_req <= '{op: i_op, a: i_rs_val, b: i_rt_val};
        end else if (r_state == MD_BUSY) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    mult_div_arith u_arith (
        .i_req (r_req),
        .o_res (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                {r_hi, r_lo} <= w_res;
            end else if (w_mt) begin
                if (i_hilo_sel) r_hi <= i_rs_val;
                else            r_lo <= i_rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {HI,LO} pushed at issue, popped
// and compared by a monitor whenever done pulses; timing checked inline.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic        i_cancel = 1'b0;
    logic        i_hilo_we = 1'b0;
    logic        i_hilo_sel = 1'b0;
    logic [31:0] i_rs_val = '0;
    logic [31:0] i_rt_val = '0;
    logic        o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] pend_hi, pend_lo;

    localparam int ML = 5;
    localparam int DL = 10;

    mult_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_cancel   (i_cancel),
        .i_hilo_we  (i_hilo_we),
        .i_hilo_sel (i_hilo_sel),
        .i_rs_val   (i_rs_val),
        .i_rt_val   (i_rt_val),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got hi=%h lo=%h expected no done", o_hi, o_lo);
            end else begin
                chk("sb_result", {o_hi, o_lo}, sb_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle; returns in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] eh, input logic [31:0] el);
        chk("idle_at_issue", {63'd0, o_busy}, 64'd0);
        i_start = 1'b1; i_op = op; i_rs_val = rs; i_rt_val = rt;
        sb_q.push_back({eh, el});
        pend_hi = eh; pend_lo = el;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic wait_busy(input int n);
        for (int k = 0; k < n; k++) begin
            chk("busy_window", {62'd0, o_busy, o_done}, {62'd0, 1'b1, 1'b0});
            chk("hilo_hold", {o_hi, o_lo}, {m_hi, m_lo});
            cyc();
        end
    endtask

    // In cycle T+LAT+1: busy low, done high, HI/LO now hold the result.
    task automatic finish_chk();
        chk("done_cycle", {62'd0, o_busy, o_done}, {62'd0, 1'b0, 1'b1});
        m_hi = pend_hi; m_lo = pend_lo;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el);
        issue(op, rs, rt, eh, el);
        wait_busy(op[1] ? DL : ML);
        finish_chk();
    endtask

    initial begin
        #12;
        chk("reset_state", {o_busy, o_done, o_hi, o_lo}, 66'd0);
        rst = 1'b0;
        cyc();

        // Signed mult, then done must be a single-cycle pulse.
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        cyc();
        chk("done_one_shot", {62'd0, o_busy, o_done}, 64'd0);

        // multu then divu started in the done cycle (back-to-back).
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        cyc();

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        cyc();

        // mthi / mtlo while idle: zero extra latency.
        i_hilo_we = 1'b1; i_hilo_sel = 1'b1; i_rs_val = 32'h1234_5678;
        cyc();
        i_hilo_we = 1'b0;
        m_hi = 32'h1234_5678;
        chk("mthi_idle", {o_hi, o_lo}, {m_hi, m_lo});
        i_hilo_we = 1'b1; i_hilo_sel = 1'b0; i_rs_val = 32'hCAFE_F00D;
        cyc();
        i_hilo_we = 1'b0;
        m_lo = 32'hCAFE_F00D;
        chk("mtlo_idle", {o_hi, o_lo}, {m_hi, m_lo});

        // mthi during busy is ignored.
        issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_busy(1);
        i_hilo_we = 1'b1; i_hilo_sel = 1'b1; i_rs_val = 32'hDEAD_BEEF;
        wait_busy(2);
        i_hilo_we = 1'b0;
        wait_busy(ML - 3);
        finish_chk();
        cyc();

        // start + hilo_we together: only the start takes effect.
        i_hilo_we = 1'b1; i_hilo_sel = 1'b0;
        issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        i_hilo_we = 1'b0;
        wait_busy(ML);
        finish_chk();
        cyc();

        // Cancelled start: nothing happens.
        i_start = 1'b1; i_cancel = 1'b1; i_op = 2'b00; i_rs_val = 32'd9; i_rt_val = 32'd9;
        cyc();
        i_start = 1'b0; i_cancel = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("cancel_start", {o_busy, o_done, o_hi, o_lo}, {2'b00, m_hi, m_lo});
            cyc();
        end

        // Cancel in flight at T+2 does not disturb the operation.
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_busy(1);
        i_cancel = 1'b1;
        wait_busy(1);
        i_cancel = 1'b0;
        wait_busy(ML - 2);
        finish_chk();
        cyc();

        // Reset in cycle T+3 of a div aborts it immediately.
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_busy(2);
        rst = 1'b1;
        #1;
        chk("async_reset_abort", {o_busy, o_done, o_hi, o_lo}, 66'd0);
        sb_q.delete();
        m_hi = '0; m_lo = '0;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < DL + 2; k++) begin
            chk("no_done_after_reset", {62'd0, o_busy, o_done}, 64'd0);
            cyc();
        end

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        cyc();
        cyc();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
